// File: rtl/ram_16x8_loader.sv
// ram_16x8_loader
// Program-mode sequencer for the SAP-1 16x8 RAM. Takes a byte stream over a
// valid/ready handshake and writes consecutive RAM addresses starting at 0,
// producing setup / write-pulse / hold timing on the RAM pins, then returns
// the RAM to run mode.
//
// Optional build macro: READBACK_VERIFY_EN (adds a readback compare per byte).
//
// Ports:
//   clk, clr            clock (rising edge), async active-high reset
//   start               one-cycle request to begin a load session
//   in_valid/in_ready   byte handshake, in_data is the byte
//   ram_address         RAM address (0..WORDS-1)
//   ram_data            RAM programmer_data
//   ram_run_or_prog     0 = program, 1 = run
//   ram_write_bar       0 = write strobe active
//   busy, done          session in progress / sticky completion flag
//   mem_value           RAM read data              (READBACK_VERIFY_EN)
//   verify_error        sticky readback mismatch   (READBACK_VERIFY_EN)
//   error_addr          first mismatching address  (READBACK_VERIFY_EN)
//
// state    | meaning
// IDLE     | waiting for start, RAM in run mode
// ACCEPT   | in_ready high, waiting for a byte
// SETUP    | address/data settle before the strobe
// WRITE    | write strobe low for WR_PULSE cycles
// HOLD     | strobe released, address/data held
// READBACK | compare RAM read data to the written byte (verify build only)
module ram_16x8_loader #(
  parameter int WORDS    = 16,
  parameter int WR_PULSE = 2
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       start,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  output logic [3:0] ram_address,
  output logic [7:0] ram_data,
  output logic       ram_run_or_prog,
  output logic       ram_write_bar,
  output logic       busy,
  output logic       done
`ifdef READBACK_VERIFY_EN
  ,
  input  logic [7:0] mem_value,
  output logic       verify_error,
  output logic [3:0] error_addr
`endif
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] ACCEPT   = 3'd1;
  localparam logic [2:0] SETUP    = 3'd2;
  localparam logic [2:0] WRITE    = 3'd3;
  localparam logic [2:0] HOLD     = 3'd4;
`ifdef READBACK_VERIFY_EN
  localparam logic [2:0] READBACK = 3'd5;
`endif

  localparam int CW = (WR_PULSE > 1) ? $clog2(WR_PULSE) : 1;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    addr_q, addr_d;
  logic [7:0]    data_q, data_d;
  logic          rop_q, rop_d;
  logic          wb_q, wb_d;
  logic          in_ready_q, in_ready_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          next_byte;
`ifdef READBACK_VERIFY_EN
  logic          verr_q, verr_d;
  logic [3:0]    eaddr_q, eaddr_d;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    data_d     = data_q;
    rop_d      = rop_q;
    wb_d       = wb_q;
    in_ready_d = in_ready_q;
    busy_d     = busy_q;
    done_d     = done_q;
    next_byte  = 1'b0;
`ifdef READBACK_VERIFY_EN
    verr_d     = verr_q;
    eaddr_d    = eaddr_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = ACCEPT;
          busy_d     = 1'b1;
          done_d     = 1'b0;
          rop_d      = 1'b0;
          addr_d     = 4'd0;
          in_ready_d = 1'b1;
`ifdef READBACK_VERIFY_EN
          verr_d     = 1'b0;
          eaddr_d    = 4'd0;
`endif
        end
      end
      ACCEPT: begin
        if (in_valid && in_ready_q) begin
          data_d     = in_data;
          in_ready_d = 1'b0;
          state_d    = SETUP;
        end
      end
      SETUP: begin
        wb_d    = 1'b0;
        cnt_d   = CW'(WR_PULSE - 1);
        state_d = WRITE;
      end
      WRITE: begin
        // down-counter: terminal count releases the strobe
        if (cnt_q == '0) begin
          wb_d    = 1'b1;
          state_d = HOLD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      HOLD: begin
`ifdef READBACK_VERIFY_EN
        state_d = READBACK;
`else
        next_byte = 1'b1;
`endif
      end
`ifdef READBACK_VERIFY_EN
      READBACK: begin
        // only the first mismatch is recorded
        if ((mem_value != data_q) && !verr_q) begin
          verr_d  = 1'b1;
          eaddr_d = addr_q;
        end
        next_byte = 1'b1;
      end
`endif
      default: state_d = IDLE;
    endcase

    if (next_byte) begin
      if (addr_q == 4'(WORDS - 1)) begin
        rop_d   = 1'b1;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = IDLE;
      end else begin
        addr_d     = addr_q + 4'd1;
        in_ready_d = 1'b1;
        state_d    = ACCEPT;
      end
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      addr_q     <= 4'd0;
      data_q     <= 8'd0;
      rop_q      <= 1'b1;
      wb_q       <= 1'b1;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef READBACK_VERIFY_EN
      verr_q     <= 1'b0;
      eaddr_q    <= 4'd0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      rop_q      <= rop_d;
      wb_q       <= wb_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
`ifdef READBACK_VERIFY_EN
      verr_q     <= verr_d;
      eaddr_q    <= eaddr_d;
`endif
    end
  end

  assign in_ready        = in_ready_q;
  assign ram_address     = addr_q;
  assign ram_data        = data_q;
  assign ram_run_or_prog = rop_q;
  assign ram_write_bar   = wb_q;
  assign busy            = busy_q;
  assign done            = done_q;
`ifdef READBACK_VERIFY_EN
  assign verify_error    = verr_q;
  assign error_addr      = eaddr_q;
`endif

endmodule

// File: tb/tb_ram_16x8_loader.sv
module tb_ram_16x8_loader;

  logic       clk = 1'b0;
  logic       clr, start, in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic [3:0] ram_address;
  logic [7:0] ram_data;
  logic       ram_run_or_prog, ram_write_bar, busy, done;
`ifdef READBACK_VERIFY_EN
  logic [7:0] mem_value;
  logic       verify_error;
  logic [3:0] error_addr;
  localparam int PER = 6;
`else
  localparam int PER = 5;
`endif

  typedef struct packed {
    logic [3:0] a;
    logic [7:0] d;
  } exp_t;

  exp_t       q[$];
  logic [7:0] mem [16];
  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  int         t0 = 0;
  int         pulses = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

`ifdef READBACK_VERIFY_EN
  // RAM model read port, bit 2 stuck at 0 at address 9
  assign mem_value = (ram_address == 4'd9) ? (mem[9] & 8'hFB) : mem[ram_address];
`endif

  ram_16x8_loader dut (
    .clk(clk), .clr(clr), .start(start),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .ram_address(ram_address), .ram_data(ram_data),
    .ram_run_or_prog(ram_run_or_prog), .ram_write_bar(ram_write_bar),
    .busy(busy), .done(done)
`ifdef READBACK_VERIFY_EN
    , .mem_value(mem_value), .verify_error(verify_error), .error_addr(error_addr)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] pat(input int p, input int k);
    case (p)
      0:       return 8'((k + 13) % 16);
      1:       return 8'(8'hF0 ^ k);
      2:       return 8'(k * 37 + 5);
      default: return (k == 9) ? 8'h04 : 8'(k);
    endcase
  endfunction

  // RAM model write side plus write-pulse scoreboard, sampled on falling edges
  initial begin
    logic       prev_wb;
    int         low;
    logic [3:0] la, pa;
    logic [7:0] ld, pd;
    exp_t       e;
    prev_wb = 1'b1; low = 0; la = '0; ld = '0; pa = '0; pd = '0;
    forever begin
      @(negedge clk);
      if (clr) begin
        prev_wb = 1'b1;
        low = 0;
        q.delete();
      end else begin
        if (!ram_write_bar) mem[ram_address] = ram_data;
        if (!ram_write_bar && prev_wb) begin
          check("pulse_has_byte", 32'(q.size() != 0), 1);
          if (q.size() != 0) begin
            e = q.pop_front();
            check("wr_addr", ram_address, e.a);
            check("wr_data", ram_data, e.d);
          end
          check("setup_addr_stable", ram_address, pa);
          check("setup_data_stable", ram_data, pd);
          check("wr_prog_mode", ram_run_or_prog, 0);
          la = ram_address; ld = ram_data; low = 1;
        end else if (!ram_write_bar) begin
          low++;
          check("wr_addr_stable", ram_address, la);
          check("wr_data_stable", ram_data, ld);
        end else if (!prev_wb) begin
          check("pulse_width", low, 2);
          check("hold_addr", ram_address, la);
          check("hold_data", ram_data, ld);
          pulses++;
        end
        prev_wb = ram_write_bar;
      end
      pa = ram_address; pd = ram_data;
    end
  end

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    t0 = cyc;
    start = 1'b0;
  endtask

  task automatic stream(input int n, input bit gapped, input int p, input int start_at);
    int  i = 0;
    int  c = 0;
    int  phase = 0;
    bit  hs;
    bit  fired = 0;
    while (i < n && c < 2000) begin
      @(negedge clk);
      in_valid = gapped ? (phase == 0) : 1'b1;
      in_data  = pat(p, i);
      if (i == start_at && !fired) begin
        start = 1'b1;
        fired = 1;
      end else begin
        start = 1'b0;
      end
      hs = in_valid && in_ready;
      @(posedge clk);
      if (hs) begin
        q.push_back({4'(i), pat(p, i)});
        i++;
      end
      phase = (phase + 1) % 4;
      c++;
    end
    #1;
    in_valid = 1'b0;
    start = 1'b0;
    if (i < n) check("stream_budget", i, n);
  endtask

  task automatic wait_done(input int exp_cycles);
    int c = 0;
    @(negedge clk);
    while (!done && c < 400) begin
      @(negedge clk);
      c++;
    end
    check("done_seen", done, 1);
    if (exp_cycles > 0) check("done_edge", cyc - t0, exp_cycles);
    check("done_run_mode", ram_run_or_prog, 1);
    check("done_not_busy", busy, 0);
    check("done_queue_empty", q.size(), 0);
  endtask

  initial begin
    clr = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    #3 clr = 1'b1;
    #1;
    check("rst_rop", ram_run_or_prog, 1);
    check("rst_wb", ram_write_bar, 1);
    check("rst_in_ready", in_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_addr", ram_address, 0);
    check("rst_data", ram_data, 0);
`ifdef READBACK_VERIFY_EN
    check("rst_verr", verify_error, 0);
    check("rst_eaddr", error_addr, 0);
`endif
    #20;
    @(negedge clk);
    clr = 1'b0;

    // full load, in_valid held high
    pulses = 0;
    do_start();
    check("start_busy", busy, 1);
    check("start_prog", ram_run_or_prog, 0);
    check("start_ready", in_ready, 1);
    stream(16, 0, 0, -1);
    wait_done(16 * PER);
    check("full_pulses", pulses, 16);
    check("ram_rd_5", mem[5], 8'd2);
    check("ram_rd_0", mem[0], 8'd13);

    // start after done restarts; start mid-session is ignored
    pulses = 0;
    do_start();
    check("restart_done_clr", done, 0);
    check("restart_addr", ram_address, 0);
    check("restart_busy", busy, 1);
    stream(16, 0, 1, 4);
    wait_done(16 * PER);
    check("restart_pulses", pulses, 16);
    check("restart_mem15", mem[15], pat(1, 15));

    // abort during the write of address 7
    do_start();
    stream(8, 0, 0, -1);
    begin
      int c = 0;
      @(negedge clk);
      while (ram_write_bar && c < 50) begin
        @(negedge clk);
        c++;
      end
    end
    check("abort_in_write", ram_write_bar, 0);
    check("abort_addr7", ram_address, 7);
    #2 clr = 1'b1;
    #1;
    check("abort_wb", ram_write_bar, 1);
    check("abort_rop", ram_run_or_prog, 1);
    check("abort_busy", busy, 0);
    check("abort_addr", ram_address, 0);
    @(negedge clk);
    @(negedge clk);
    #2 clr = 1'b0;

    // reload from address 0 with a gapped source
    pulses = 0;
    do_start();
    check("abort_restart_addr", ram_address, 0);
    stream(16, 1, 2, -1);
    wait_done(0);
    check("gap_pulses", pulses, 16);
    check("gap_mem3", mem[3], pat(2, 3));
    check("gap_mem15", mem[15], pat(2, 15));

`ifdef READBACK_VERIFY_EN
    pulses = 0;
    do_start();
    check("verify_start_clr", verify_error, 0);
    stream(16, 0, 3, -1);
    wait_done(16 * PER);
    check("verify_error", verify_error, 1);
    check("verify_addr", error_addr, 9);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
